instruction_fetch: RTL

Fetch stage directly downstream of the program counter. Accepts a byte address from the PC over a valid/ready handshake and reads the 32-bit instruction as four bytes over a byte-wide, ack-based memory port. It assembles the bytes little-endian and presents the instruction plus its PC to decode over a second valid/ready handshake. A flush input lets a redirect abort a fetch in progress.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/instr_assembler.sv | 34 +++
 rtl/instruction_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, widths and the word-alignment helper.
// ADDR_W matches the program counter width so both stages agree on the address space.
package fetch_pkg;

  localparam int ADDR_W          = 8;
  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;
  localparam int BYTE_IDX_W      = $clog2(BYTES_PER_INSTR);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_INSTR - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    HOLD = ST_HOLD
  } fetch_state_e;

  // Instructions are always read from the word containing the PC.
  function automatic logic [ADDR_W-1:0] alignBase(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:BYTE_IDX_W], {BYTE_IDX_W{1'b0}}};
  endfunction

endpackage

// File: rtl/instr_assembler.sv
// Four-lane byte register that builds a little-endian instruction word one byte at a time.
// Lane 0 lands in bits [7:0]; clear has priority over any lane write.
module instr_assembler
  import fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [BYTE_IDX_W-1:0] lane_i,
  input  logic [7:0]            data_i,
  output logic [INSTR_W-1:0]    word_o
);

  logic [BYTES_PER_INSTR-1:0][7:0] bytes_q;
  logic [BYTES_PER_INSTR-1:0][7:0] bytes_d;

  always_comb begin
    bytes_d = bytes_q;
    if (we_i) begin
      bytes_d[lane_i] = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign word_o = bytes_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: takes a PC, reads four bytes over an ack-based byte port, and hands the
// assembled instruction to decode. A flush aborts whatever is in flight and returns to IDLE.
module instruction_fetch
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_misalign,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               flush
);

  fetch_state_e          state_q, state_d;
  logic [BYTE_IDX_W-1:0] byteIdx_q, byteIdx_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     instrPc_q, instrPc_d;
  logic                  misalign_q, misalign_d;
  logic                  accept;
  logic                  ackTake;

  // rst_n is active-high despite its name; gating it here keeps pc_ready low during reset.
  assign pc_ready = (state_q == IDLE) & ~flush & ~rst_n;
  assign accept   = pc_valid & pc_ready;
  assign ackTake  = (state_q == REQ) & mem_ack & ~flush;

  always_comb begin
    state_d    = state_q;
    byteIdx_d  = byteIdx_q;
    base_d     = base_q;
    instrPc_d  = instrPc_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          instrPc_d  = pc_in;
          misalign_d = |pc_in[BYTE_IDX_W-1:0];
          base_d     = alignBase(pc_in);
          byteIdx_d  = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (ackTake) begin
          if (byteIdx_q == LAST_BYTE) begin
            byteIdx_d = '0;
            state_d   = HOLD;
          end else begin
            byteIdx_d = byteIdx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flush overrides every transition above, including a completing byte or a handoff.
    if (flush) begin
      state_d   = IDLE;
      byteIdx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      byteIdx_q  <= '0;
      base_q     <= '0;
      instrPc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteIdx_q  <= byteIdx_d;
      base_q     <= base_d;
      instrPc_q  <= instrPc_d;
      misalign_q <= misalign_d;
    end
  end

  instr_assembler u_assembler (
    .clk_i   (clk),
    .clear_i (rst_n),
    .we_i    (ackTake),
    .lane_i  (byteIdx_q),
    .data_i  (mem_rdata),
    .word_o  (instr_out)
  );

  // The byte offset never carries past the aligned base, so the add cannot leave the word.
  assign mem_addr       = base_q + {{(ADDR_W-BYTE_IDX_W){1'b0}}, byteIdx_q};
  assign mem_rd         = (state_q == REQ);
  assign instr_valid    = (state_q == HOLD);
  assign instr_pc       = instrPc_q;
  assign instr_misalign = misalign_q;

endmodule
